// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: opcode values and arbitration state encoding.
package alu_pkg;

  localparam logic [2:0] AND = 3'b000;
  localparam logic [2:0] OR  = 3'b001;
  localparam logic [2:0] ADD = 3'b010;
  localparam logic [2:0] SUB = 3'b100;
  localparam logic [2:0] MUL = 3'b101;
  localparam logic [2:0] SLT = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } arb_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU shared by both arbiter ports; wrapping arithmetic, unsigned SLT.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [2:0]       ALUControl,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero
);

  always_comb begin
    ALUResult = '0;
    case (ALUControl)
      AND:     ALUResult = SrcA & SrcB;
      OR:      ALUResult = SrcA | SrcB;
      ADD:     ALUResult = SrcA + SrcB;
      SUB:     ALUResult = SrcA - SrcB;
      MUL:     ALUResult = SrcA * SrcB;
      SLT:     ALUResult = {{(WIDTH-1){1'b0}}, (SrcA < SrcB)};
      default: ALUResult = '0;
    endcase
  end

  assign Zero = (ALUResult == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between the EX stage (port 0) and an auxiliary
// requester (port 1); results land in per-port registered response slots one cycle later.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ReqValid0,
  input  logic             ReqValid1,
  output logic             ReqReady0,
  output logic             ReqReady1,
  input  logic [WIDTH-1:0] ReqSrcA0,
  input  logic [WIDTH-1:0] ReqSrcA1,
  input  logic [WIDTH-1:0] ReqSrcB0,
  input  logic [WIDTH-1:0] ReqSrcB1,
  input  logic [2:0]       ReqALUControl0,
  input  logic [2:0]       ReqALUControl1,
  output logic             RspValid0,
  output logic             RspValid1,
  input  logic             RspReady0,
  input  logic             RspReady1,
  output logic [WIDTH-1:0] RspResult0,
  output logic [WIDTH-1:0] RspResult1,
  output logic             RspZero0,
  output logic             RspZero1,
  output logic [CNT_W-1:0] Conflicts
);

  logic [1:0]       req_valid;
  logic [1:0]       rsp_ready;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_zero;
  logic [1:0]       elig;
  logic [1:0]       grant;
  logic [WIDTH-1:0] rsp_result [2];

  arb_t             arb_reg;
  logic             idle_last_reg;
  logic             last_grant;
  logic [CNT_W-1:0] conflicts_reg;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_op;
  logic [WIDTH-1:0] alu_y;
  logic             alu_zero;

  assign req_valid = {ReqValid1, ReqValid0};
  assign rsp_ready = {RspReady1, RspReady0};

  // A port may be granted only if its response slot is empty or draining this cycle.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_elig
      assign elig[gi] = ~rst & req_valid[gi] & (~rsp_valid[gi] | rsp_ready[gi]);
    end
  endgenerate

  // IDLE keeps whichever port owned the ALU most recently.
  always_comb begin
    last_grant = idle_last_reg;
    if (arb_reg == OWN0) last_grant = 1'b0;
    else if (arb_reg == OWN1) last_grant = 1'b1;
  end

  assign grant[0] = elig[0] & (~elig[1] | last_grant);
  assign grant[1] = elig[1] & (~elig[0] | ~last_grant);

  assign ReqReady0 = grant[0];
  assign ReqReady1 = grant[1];

  assign alu_a  = grant[1] ? ReqSrcA1       : ReqSrcA0;
  assign alu_b  = grant[1] ? ReqSrcB1       : ReqSrcB0;
  assign alu_op = grant[1] ? ReqALUControl1 : ReqALUControl0;

  alu #(.WIDTH(WIDTH)) u_alu (
    .SrcA       (alu_a),
    .SrcB       (alu_b),
    .ALUControl (alu_op),
    .ALUResult  (alu_y),
    .Zero       (alu_zero)
  );

  generate
    for (gi = 0; gi < 2; gi++) begin : g_rsp
      logic             valid_reg;
      logic             zero_reg;
      logic [WIDTH-1:0] result_reg;

      // A grant in the same cycle as a drain reloads the slot with no bubble.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          valid_reg  <= 1'b0;
          zero_reg   <= 1'b0;
          result_reg <= '0;
        end else if (grant[gi]) begin
          valid_reg  <= 1'b1;
          zero_reg   <= alu_zero;
          result_reg <= alu_y;
        end else if (rsp_ready[gi]) begin
          valid_reg  <= 1'b0;
        end
      end

      assign rsp_valid[gi]  = valid_reg;
      assign rsp_zero[gi]   = zero_reg;
      assign rsp_result[gi] = result_reg;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arb_reg       <= IDLE;
      idle_last_reg <= 1'b1;
      conflicts_reg <= '0;
    end else begin
      if (grant[0])      arb_reg <= OWN0;
      else if (grant[1]) arb_reg <= OWN1;
      else               arb_reg <= IDLE;
      idle_last_reg <= last_grant;
      if ((&elig) && !(&conflicts_reg))
        conflicts_reg <= conflicts_reg + CNT_W'(1);
    end
  end

  assign RspValid0  = rsp_valid[0];
  assign RspValid1  = rsp_valid[1];
  assign RspResult0 = rsp_result[0];
  assign RspResult1 = rsp_result[1];
  assign RspZero0   = rsp_zero[0];
  assign RspZero1   = rsp_zero[1];
  assign Conflicts  = conflicts_reg;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter that shares one combinational ALU instance between two requesters: port 0 is the pipeline EX stage, port 1 an auxiliary requester such as a debug or address-generation unit. Each port has a valid/ready request channel and a registered valid/ready response channel. The block grants at most one operation per cycle and returns the result one cycle after acceptance. It sits beside the EX stage and replaces a second ALU instance.

## Interface
- WIDTH, 32, operand and result width
- CNT_W, 16, width of the conflict counter
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- ReqValid0 / ReqValid1  in  1  request present on port 0 / 1
- ReqReady0 / ReqReady1  out  1  request accepted this cycle
- ReqSrcA0 / ReqSrcA1  in  WIDTH  operand A
- ReqSrcB0 / ReqSrcB1  in  WIDTH  operand B
- ReqALUControl0 / ReqALUControl1  in  3  operation code
- RspValid0 / RspValid1  out  1  registered result available
- RspReady0 / RspReady1  in  1  consumer takes result this cycle
- RspResult0 / RspResult1  out  WIDTH  registered result
- RspZero0 / RspZero1  out  1  registered, RspResult==0
- Conflicts  out  CNT_W  saturating count of cycles in which both ports were eligible

## Operation
- Opcodes:
  - 000 AND; 001 OR; 010 ADD; 100 SUB
  - 101 MUL, low WIDTH bits of the product
  - 110 SLT, unsigned compare, result 1 or 0
  - 011 and 111 produce 0
- Arithmetic wraps modulo 2^WIDTH; no overflow flag.
- Port i is eligible when ReqValid_i=1 and its response slot is free or draining, i.e. RspValid_i=0 or RspReady_i=1.
- Grant rules:
  - Only one port eligible: that port is granted.
  - Both eligible: the port other than LastGrant is granted.
  - LastGrant updates only on a grant.
  - Neither eligible: no grant, and LastGrant holds.
- ReqReady_i = grant_i, computed combinationally from eligibility. The requester must hold its operands and valid stable until ReqReady_i=1.
- On grant_i, the shared ALU computes from port i's operands. At the next edge, RspResult_i and RspZero_i load and RspValid_i sets.
- RspValid_i clears on RspReady_i=1 when there is no simultaneous grant_i. When both occur in the same cycle, the old result drains and the new one loads, so there is no bubble.
- Response registers hold their value while RspValid_i=1 and RspReady_i=0.
- Conflicts increments on each cycle where both ports are eligible and saturates at all-ones.
- State register Arb tracks the current owner:
  - Arb ∈ {IDLE, OWN0, OWN1}.
  - IDLE→OWN0 or OWN1 on a grant.
  - OWN0/OWN1 follow each cycle's grant.
  - Any state→IDLE when there is no grant.
  - LastGrant is derived from Arb, with IDLE retaining the previous owner.

## Timing
- Reset, asynchronous assert:
  - Arb=IDLE and LastGrant=1, so port 0 wins the first conflict.
  - RspValid0/1=0, RspResult0/1=0, RspZero0/1=0, Conflicts=0.
  - ReqReady0/1=0 while rst=1.
- Reset mid-operation drops any accepted-but-undelivered results. No response is issued for them.
- Latency is 1 cycle from request acceptance to RspValid.
- Throughput is one operation per cycle in aggregate.
- With both ports continuously eligible, grants alternate 0,1,0,1,…, so each port waits at most one cycle.
- A port whose response is stalled (RspValid=1, RspReady=0) is ineligible. Its share goes to the other port and the conflict does not count.
- The combinational path runs from ReqValid and RspReady, through grant, to ReqReady. The operand mux then feeds the ALU, which feeds the response register D input. This path must close at target frequency with a 32×32 multiplier.

## Structure
- Shared package alu_pkg holds:
  - The opcode localparams: AND, OR, ADD, SUB, MUL, SLT.
  - The Arb state encoding: IDLE=2'b00, OWN0=2'b01, OWN1=2'b10.
- One sub-module: the existing ALU (parameter WIDTH), instantiated once, with SrcA, SrcB and ALUControl driven by a grant-selected mux. Its Zero output is registered into RspZero of the granted port.

## Test plan
- Reset, then ReqValid0 with ADD 5+7 and RspReady0=1 → ReqReady0 same cycle; next cycle RspValid0=1, RspResult0=12, RspZero0=0.
- Both ports valid for 4 cycles, all ready high: port 0 SUB 3-3, port 1 MUL 0x10000×0x10000 → grants 0,1,0,1; RspResult0=0 with RspZero0=1; RspResult1=0 (low 32 bits) with RspZero1=1; Conflicts=4.
- RspReady1=0 with RspValid1=1, both requesting → only port 0 granted each cycle; RspResult1 holds; Conflicts unchanged.
- SLT 0xFFFFFFFF<1 on port 1 → result 0 (unsigned); opcode 111 → result 0 with RspZero=1.
- rst asserted asynchronously between grant and response → RspValid0/1=0 immediately, Conflicts=0, the next conflict is won by port 0.
- Force 2^CNT_W+3 conflict cycles → Conflicts saturates at all-ones.
